// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register write arbiter.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  // Index width for an N-entry selector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/register-side bundle of the write arbiter.
// The lock vector only exists when REG_ARB_LOCK_EN is defined.
interface reg_write_arbiter_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic [N-1:0]        req;
  logic [N-1:0][W-1:0] wdata;
`ifdef REG_ARB_LOCK_EN
  logic [N-1:0]        lock;
`endif
  logic [N-1:0]        gnt;
  logic [N-1:0]        ack;
  logic [W-1:0]        reg_d;
  logic                reg_enb;
  logic                busy;

  // Requester side (datapath blocks plus the shared register's inputs).
  modport master (
    output req, wdata,
`ifdef REG_ARB_LOCK_EN
    output lock,
`endif
    input  gnt, ack, reg_d, reg_enb, busy
  );

  // Arbiter side.
  modport slave (
    input  req, wdata,
`ifdef REG_ARB_LOCK_EN
    input  lock,
`endif
    output gnt, ack, reg_d, reg_enb, busy
  );
endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Rotate-priority picker: first set req bit at ptr, ptr+1, ... wrapping mod N.
// Purely combinational so other arbiters can reuse it.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] pos;

  // Scan from ptr upward; the first hit wins and masks later ones.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = '0;
    for (int i = 0; i < N; i++) begin
      pos = IW'((int'(ptr) + i) % N);
      if (!any && req[pos]) begin
        any         = 1'b1;
        idx         = pos;
        onehot[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enabled W-bit register among N requesters.
// Sequence per write: IDLE (pick) -> WRITE (reg_enb) -> ACK (ack pulse).
// Optional macro REG_ARB_LOCK_EN: owner holding lock in ACK keeps the pointer,
// so it wins every following arbitration it requests in.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input logic               clk,
  input logic               rst_,
  reg_write_arbiter_if.slave bus
);

  localparam int IW = idx_w(N);

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr, win, pick_idx;
  logic [N-1:0]  pick_oh, win_oh;
  logic          pick_any;
  logic [W-1:0]  reg_d_q;
  logic [IW-1:0] ptr_adv;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Next pointer after the current winner, wrapping mod N.
  assign ptr_adv = (win == IW'(N - 1)) ? '0 : win + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: requests only matter in IDLE; WRITE and ACK are one cycle each.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pick_any) state_nxt = WRITE;
      WRITE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner latch, write data capture and pointer update.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ptr     <= '0;
      win     <= '0;
      win_oh  <= '0;
      reg_d_q <= '0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          win     <= pick_idx;
          win_oh  <= pick_oh;
          reg_d_q <= bus.wdata[pick_idx];
        end
`ifdef REG_ARB_LOCK_EN
        ACK: ptr <= bus.lock[win] ? win : ptr_adv;
`else
        ACK: ptr <= ptr_adv;
`endif
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.gnt     = (state != IDLE) ? win_oh : '0;
    bus.ack     = (state == ACK)  ? win_oh : '0;
    bus.reg_enb = (state == WRITE);
    bus.busy    = (state != IDLE);
  end

  assign bus.reg_d = reg_d_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios then randomized rounds,
// checked against a transaction-level round-robin model.
module tb_reg_write_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic clk;
  logic rst_;

  reg_write_arbiter_if #(.W(W), .N(N)) bus ();

  reg_write_arbiter #(.W(W), .N(N)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  // Stand-in for the shared register fed by the arbiter.
  logic [W-1:0] q;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)            q <= '0;
    else if (bus.reg_enb) q <= bus.reg_d;
  end

  int           tests = 0;
  int           fails = 0;
  int           ptr_m = 0;
  logic [W-1:0] last_d = '0;
  int           order[$];
`ifdef REG_ARB_LOCK_EN
  logic [N-1:0] lk_drive = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Round-robin choice straight from the rule: first requester at p, p+1, ...
  function automatic int rr_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (((r >> ((p + k) % N)) & N'(1)) != 0) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk_idle();
    chk("idle.busy", 32'(bus.busy), 32'(0));
    chk("idle.gnt",  32'(bus.gnt),  32'(0));
    chk("idle.ack",  32'(bus.ack),  32'(0));
    chk("idle.enb",  32'(bus.reg_enb), 32'(0));
    chk("idle.d",    32'(bus.reg_d), 32'(last_d));
  endtask

  // One arbitration opportunity; entered and left at a negedge with DUT idle.
  // 'during' replaces req while the write is in flight (must be ignored).
  task automatic round(input logic [N-1:0] r, input logic [N*W-1:0] d,
                       input logic [N-1:0] during);
    int           w;
    logic [W-1:0] e;
    logic [N-1:0] oh;
    chk_idle();
    bus.req   = r;
    bus.wdata = d;
`ifdef REG_ARB_LOCK_EN
    bus.lock  = lk_drive;
`endif
    w = rr_winner(r, ptr_m);
    @(negedge clk);
    if (w >= 0) begin
      e  = W'(d >> (w * W));
      oh = N'(1) << w;
      order.push_back(w);
      chk("wr.busy", 32'(bus.busy), 32'(1));
      chk("wr.gnt",  32'(bus.gnt),  32'(oh));
      chk("wr.enb",  32'(bus.reg_enb), 32'(1));
      chk("wr.ack",  32'(bus.ack),  32'(0));
      chk("wr.d",    32'(bus.reg_d), 32'(e));
      bus.req = during;
      @(negedge clk);
      chk("ack.ack", 32'(bus.ack), 32'(oh));
      chk("ack.gnt", 32'(bus.gnt), 32'(oh));
      chk("ack.enb", 32'(bus.reg_enb), 32'(0));
      chk("ack.busy", 32'(bus.busy), 32'(1));
      chk("ack.q",   32'(q), 32'(e));
      last_d = e;
`ifdef REG_ARB_LOCK_EN
      if (((lk_drive >> w) & N'(1)) != 0) ptr_m = w;
      else                                ptr_m = (w + 1) % N;
`else
      ptr_m = (w + 1) % N;
`endif
      @(negedge clk);
    end
  endtask

  initial begin
    int          fair_exp[5];
    int          wrap_exp[3];
    logic [63:0] rnd;
    fair_exp = '{0, 1, 2, 3, 0};
    wrap_exp = '{2, 3, 0};

    rst_      = 1'b0;
    bus.req   = '0;
    bus.wdata = '0;
`ifdef REG_ARB_LOCK_EN
    bus.lock  = '0;
`endif
    #2;
    chk("rst.busy", 32'(bus.busy), 32'(0));
    chk("rst.gnt",  32'(bus.gnt),  32'(0));
    chk("rst.ack",  32'(bus.ack),  32'(0));
    chk("rst.enb",  32'(bus.reg_enb), 32'(0));
    chk("rst.d",    32'(bus.reg_d), 32'(0));
    @(negedge clk);
    rst_ = 1'b1;

    // Single requester.
    round(4'b0001, 32'h0000_00A5, 4'b0001);
    chk("single.q", 32'(q), 32'h A5);

    // Reset in the middle of a write: no ack, everything back to zero.
    bus.req   = 4'b0010;
    bus.wdata = 32'h1122_3344;
    @(negedge clk);
    chk("midrst.busy_before", 32'(bus.busy), 32'(1));
    rst_ = 1'b0;
    #1;
    chk("midrst.busy", 32'(bus.busy), 32'(0));
    chk("midrst.gnt",  32'(bus.gnt),  32'(0));
    chk("midrst.ack",  32'(bus.ack),  32'(0));
    chk("midrst.enb",  32'(bus.reg_enb), 32'(0));
    chk("midrst.d",    32'(bus.reg_d), 32'(0));
    bus.req = '0;
    @(negedge clk);
    rst_   = 1'b1;
    ptr_m  = 0;
    last_d = '0;

    // Contention: all four held, service order restarts from pointer 0.
    order.delete();
    for (int k = 0; k < 5; k++)
      round(4'b1111, 32'h4030_2010 + 32'(k) * 32'h0101_0101, 4'b1111);
    for (int k = 0; k < 5; k++)
      chk("fair.order", 32'(order[k]), 32'(fair_exp[k]));

    // Wrap-around: serve 2, then 1001 picks 3 before 0.
    order.delete();
    round(4'b0100, 32'h00BB_0000, 4'b0100);
    round(4'b1001, 32'hC300_00C0, 4'b1001);
    round(4'b1001, 32'hD300_00D0, 4'b1001);
    for (int k = 0; k < 3; k++)
      chk("wrap.order", 32'(order[k]), 32'(wrap_exp[k]));

    // Early drop: requester 1 withdraws during WRITE, write still acked.
    round(4'b0010, 32'h0000_5A00, 4'b0000);
    chk("drop.q", 32'(q), 32'h5A);

`ifdef REG_ARB_LOCK_EN
    // Lock: owner 2 keeps winning while locked; after unlock, 1 is next.
    order.delete();
    lk_drive = 4'b0100;
    round(4'b0110, 32'h0077_6600, 4'b0110);
    round(4'b0110, 32'h0078_6700, 4'b0110);
    round(4'b0110, 32'h0079_6800, 4'b0110);
    lk_drive = 4'b0000;
    round(4'b0110, 32'h007A_6900, 4'b0110);
    round(4'b0110, 32'h007B_6A00, 4'b0110);
    chk("lock.last", 32'(order[order.size() - 1]), 32'(1));
`endif

    // Randomized rounds, including idle requests and in-flight req noise.
    for (int n = 0; n < 300; n++) begin
      rnd = {$urandom(), $urandom()};
`ifdef REG_ARB_LOCK_EN
      lk_drive = N'($urandom());
`endif
      round(N'($urandom()), rnd[N*W-1:0], N'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
